// File: rtl/serial_frame_deserializer_pkg.sv
// Shared types and defaults for the serial frame deserializer.
//   state_e        : framing state (hunt for sync / collect words)
//   Default*       : default sync pattern, word width and frame length
//   cnt_w()        : counter width helper, never narrower than one bit
package serial_frame_deserializer_pkg;

   typedef enum logic {
      StHunt,
      StCollect
   } state_e;

   localparam int unsigned DefaultWidth         = 8;
   localparam int unsigned DefaultSyncLen       = 4;
   localparam logic [3:0]  DefaultSync          = 4'b1011;
   localparam int unsigned DefaultWordsPerFrame = 2;

   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned DefaultBitCntW  = cnt_w(DefaultWidth);
   localparam int unsigned DefaultWordCntW = cnt_w(DefaultWordsPerFrame + 1);

endpackage

// File: rtl/serial_frame_deserializer_if.sv
// Bundles the serial input, the word output handshake and the status flags.
//   master : producer of din/din_valid and consumer side (dout_ready, clear_ovf)
//   slave  : the deserializer itself
interface serial_frame_deserializer_if #(
   parameter int unsigned WIDTH = 8
);
   logic             din;
   logic             din_valid;
   logic             dout_ready;
   logic             clear_ovf;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             locked;
   logic             overflow;

   modport master (
      output din, din_valid, dout_ready, clear_ovf,
      input  dout, dout_valid, locked, overflow
   );

   modport slave (
      input  din, din_valid, dout_ready, clear_ovf,
      output dout, dout_valid, locked, overflow
   );
endinterface

// File: rtl/serial_frame_deserializer_sync_pattern_detector.sv
// Sliding window over the incoming bit stream, compared against the sync pattern.
//   clk, rst  : clock, asynchronous active-high reset
//   din       : serial bit
//   din_valid : shift din into the window this edge
//   clear     : zero the window (wins over a shift)
//   match     : the window including the current bit equals SYNC
module serial_frame_deserializer_sync_pattern_detector
   import serial_frame_deserializer_pkg::*;
#(
   parameter int unsigned           SYNC_LEN = DefaultSyncLen,
   parameter logic [SYNC_LEN-1:0]   SYNC     = DefaultSync
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   input  logic din_valid,
   input  logic clear,
   output logic match
);

   logic [SYNC_LEN-1:0] window_q, window_d, shifted;

   // Match looks at the updated window so overlapping patterns are caught.
   always_comb begin
      shifted  = {window_q[SYNC_LEN-2:0], din};
      match    = din_valid && (shifted == SYNC);
      window_d = window_q;
      if (clear) begin
         window_d = '0;
      end else if (din_valid) begin
         window_d = shifted;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         window_q <= '0;
      end else begin
         window_q <= window_d;
      end
   end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Hunts for a sync pattern in a serial stream, then assembles WORDS_PER_FRAME
// words of WIDTH bits MSB-first and offers each on a one-entry output register.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of serial_frame_deserializer_if
//              (din, din_valid, dout_ready, clear_ovf -> dout, dout_valid,
//               locked, overflow)
module serial_frame_deserializer
   import serial_frame_deserializer_pkg::*;
#(
   parameter int unsigned         WIDTH           = DefaultWidth,
   parameter int unsigned         SYNC_LEN        = DefaultSyncLen,
   parameter logic [SYNC_LEN-1:0] SYNC            = DefaultSync,
   parameter int unsigned         WORDS_PER_FRAME = DefaultWordsPerFrame
) (
   input logic                          clk,
   input logic                          rst,
   serial_frame_deserializer_if.slave   bus
);

   localparam int unsigned BitCntW  = cnt_w(WIDTH);
   localparam int unsigned WordCntW = cnt_w(WORDS_PER_FRAME + 1);

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    shreg_q, shreg_d;
   logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WordCntW-1:0] word_cnt_q, word_cnt_d;
   logic [WIDTH-1:0]    dout_q, dout_d;
   logic                dout_valid_q, dout_valid_d;
   logic                locked_q, locked_d;
   logic                overflow_q, overflow_d;

   logic                hunt_valid;
   logic                match;
   logic                det_clear;
   logic                word_done;
   logic [WIDTH-1:0]    word;
   logic [WordCntW-1:0] word_cnt_inc;

   // The window only advances while hunting, so it stays zero through a frame.
   assign hunt_valid = bus.din_valid && (state_q == StHunt);

   serial_frame_deserializer_sync_pattern_detector #(
      .SYNC_LEN (SYNC_LEN),
      .SYNC     (SYNC)
   ) u_sync_det (
      .clk       (clk),
      .rst       (rst),
      .din       (bus.din),
      .din_valid (hunt_valid),
      .clear     (det_clear),
      .match     (match)
   );

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      word_cnt_d   = word_cnt_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      overflow_d   = overflow_q;
      det_clear    = 1'b0;
      word_done    = 1'b0;
      word         = {shreg_q[WIDTH-2:0], bus.din};
      word_cnt_inc = word_cnt_q + 1'b1;

      unique case (state_q)
         StHunt: begin
            if (match) begin
               state_d    = StCollect;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               det_clear  = 1'b1;
            end
         end
         StCollect: begin
            if (bus.din_valid) begin
               shreg_d = word;
               if (bit_cnt_q == BitCntW'(WIDTH - 1)) begin
                  bit_cnt_d  = '0;
                  word_done  = 1'b1;
                  word_cnt_d = word_cnt_inc;
                  if (word_cnt_inc == WordCntW'(WORDS_PER_FRAME)) begin
                     state_d   = StHunt;
                     det_clear = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StHunt;
      endcase

      // Clear first so a same-edge drop still sets the flag.
      if (bus.clear_ovf) begin
         overflow_d = 1'b0;
      end

      if (word_done) begin
         // A consumer taking the held word frees the slot on this same edge.
         if (!dout_valid_q || bus.dout_ready) begin
            dout_d       = word;
            dout_valid_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end else if (dout_valid_q && bus.dout_ready) begin
         dout_valid_d = 1'b0;
      end

      locked_d = (state_d == StCollect);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StHunt;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         word_cnt_q   <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         word_cnt_q   <= word_cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         locked_q     <= locked_d;
         overflow_q   <= overflow_d;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.locked     = locked_q;
   assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench for serial_frame_deserializer with default parameters.
module tb_serial_frame_deserializer;

   logic clk;
   logic rst;

   serial_frame_deserializer_if #(.WIDTH(8)) bus ();

   serial_frame_deserializer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       din;
      logic       din_valid;
      logic       dout_ready;
      logic       clear_ovf;
      logic       exp_valid;
      logic [7:0] exp_dout;
      logic       exp_locked;
      logic       exp_ovf;
   } vec_t;

   vec_t vec_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic v, input logic [7:0] d,
                             input logic l, input logic o);
      check({tag, ".dout_valid"}, {7'd0, bus.dout_valid}, {7'd0, v});
      check({tag, ".dout"}, bus.dout, d);
      check({tag, ".locked"}, {7'd0, bus.locked}, {7'd0, l});
      check({tag, ".overflow"}, {7'd0, bus.overflow}, {7'd0, o});
   endtask

   // Inputs change 1 time unit after an edge; outputs sampled at the same point.
   task automatic step(input logic b, input logic v);
      bus.din       = b;
      bus.din_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) step(w[i], 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.din_valid  = 1'b0;
      bus.clear_ovf  = 1'b0;
      bus.dout_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic push(input logic b, input logic v, input logic ev, input logic [7:0] ed,
                       input logic el);
      vec_t r;
      r.din = b; r.din_valid = v; r.dout_ready = 1'b1; r.clear_ovf = 1'b0;
      r.exp_valid = ev; r.exp_dout = ed; r.exp_locked = el; r.exp_ovf = 1'b0;
      vec_q.push_back(r);
   endtask

   // Expected trace of sync 1011 + two words with dout_ready=1 and `stalls`
   // idle cycles after every valid bit.
   task automatic build_frame(input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] prev, input int stalls);
      logic [3:0]  sync_bits;
      logic [7:0]  words [2];
      logic [7:0]  cur;
      logic        lk;
      logic        last;
      sync_bits = 4'b1011;
      words[0]  = w0;
      words[1]  = w1;
      cur       = prev;
      for (int k = 0; k < 4; k++) begin
         lk = (k == 3);
         push(sync_bits[3-k], 1'b1, 1'b0, cur, lk);
         for (int s = 0; s < stalls; s++) push(1'b0, 1'b0, 1'b0, cur, lk);
      end
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 8; i++) begin
            last = (i == 7);
            if (last) cur = words[w];
            lk = !(last && w == 1);
            push(words[w][7-i], 1'b1, last, cur, lk);
            for (int s = 0; s < stalls; s++) push(1'b1, 1'b0, 1'b0, cur, lk);
         end
      end
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < vec_q.size(); i++) begin
         bus.dout_ready = vec_q[i].dout_ready;
         bus.clear_ovf  = vec_q[i].clear_ovf;
         step(vec_q[i].din, vec_q[i].din_valid);
         check_outs($sformatf("%s[%0d]", tag, i), vec_q[i].exp_valid, vec_q[i].exp_dout,
                    vec_q[i].exp_locked, vec_q[i].exp_ovf);
      end
      vec_q.delete();
   endtask

   initial begin
      bus.din = 1'b0;
      do_reset();
      check_outs("reset", 1'b0, 8'h00, 1'b0, 1'b0);

      // Basic frame
      build_frame(8'hA5, 8'h3C, 8'h00, 0);
      run_table("basic");
      step(1'b0, 1'b0);
      check_outs("basic_idle", 1'b0, 8'h3C, 1'b0, 1'b0);

      // Asynchronous reset between edges with nonzero dout held
      #2 rst = 1'b1;
      #1;
      check_outs("async_rst", 1'b0, 8'h00, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      step(1'b0, 1'b0);
      check_outs("post_rst", 1'b0, 8'h00, 1'b0, 1'b0);

      // Overlapping sync: lock only after the 6th bit
      do_reset();
      bus.dout_ready = 1'b1;
      step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
      check("ovl.locked4", {7'd0, bus.locked}, 8'd0);
      step(1'b1, 1'b1);
      check("ovl.locked5", {7'd0, bus.locked}, 8'd0);
      step(1'b1, 1'b1);
      check("ovl.locked6", {7'd0, bus.locked}, 8'd1);
      send_byte(8'hFF);
      check_outs("ovl.word", 1'b1, 8'hFF, 1'b1, 1'b0);
      send_byte(8'h00);
      check_outs("ovl.end", 1'b1, 8'h00, 1'b0, 1'b0);

      // Backpressure with overflow; clear on the drop edge loses to the set
      do_reset();
      bus.dout_ready = 1'b0;
      step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
      send_byte(8'h12);
      check_outs("bp.first", 1'b1, 8'h12, 1'b1, 1'b0);
      for (int i = 7; i >= 1; i--) step(8'h34 >> i, 1'b1);
      bus.clear_ovf = 1'b1;
      step(1'b0, 1'b1);
      bus.clear_ovf = 1'b0;
      check_outs("bp.drop", 1'b1, 8'h12, 1'b0, 1'b1);
      bus.dout_ready = 1'b1;
      step(1'b0, 1'b0);
      bus.dout_ready = 1'b0;
      check_outs("bp.consume", 1'b0, 8'h12, 1'b0, 1'b1);
      bus.clear_ovf = 1'b1;
      step(1'b0, 1'b0);
      bus.clear_ovf = 1'b0;
      check_outs("bp.clear", 1'b0, 8'h12, 1'b0, 1'b0);

      // Stalls: two idle cycles after every valid bit
      do_reset();
      build_frame(8'hA5, 8'h3C, 8'h00, 2);
      run_table("stall");

      // Reset mid-word leaves no residue
      do_reset();
      bus.dout_ready = 1'b1;
      step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
      check("mid.locked_pre", {7'd0, bus.locked}, 8'd1);
      #2 rst = 1'b1;
      #1;
      check("mid.locked", {7'd0, bus.locked}, 8'd0);
      check("mid.valid", {7'd0, bus.dout_valid}, 8'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      build_frame(8'h5A, 8'hC3, 8'h00, 0);
      run_table("mid");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/serial_frame_deserializer.md
Name: serial_frame_deserializer

Overview:
Consumes the registered serial bit stream produced by the single-bit D flip-flop stage. Hunts for a fixed sync pattern, then assembles a fixed number of WIDTH-bit words MSB-first. Presents each word on a one-entry output register with a valid/ready handshake. Sits directly downstream of the bit register and feeds word-level logic.

Parameters:
WIDTH, 8, bits per assembled word (>=2)
SYNC_LEN, 4, sync pattern length in bits (>=2, <=16)
SYNC, 4'b1011, sync pattern; bit SYNC_LEN-1 is the first bit received
WORDS_PER_FRAME, 2, words collected per sync before returning to hunt (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
din  input  1  serial data bit (registered flip-flop output)
din_valid  input  1  din is sampled only when high
dout_ready  input  1  consumer accepts dout when high with dout_valid
clear_ovf  input  1  synchronous clear of the overflow flag
dout  output  WIDTH  assembled word, MSB = first bit received
dout_valid  output  1  dout holds an unconsumed word
locked  output  1  high while in COLLECT
overflow  output  1  sticky; a completed word was dropped

Behaviour:
- Reset: async, active-high. Takes effect immediately, not at the next edge.
  - All outputs are 0; state = HUNT; sync window, bit counter and word counter are 0.
  - Reset mid-word or mid-frame discards the partial word and any held dout.
- A clock edge with din_valid=0 leaves the window, counters and state unchanged. The output handshake still operates on that edge.
- HUNT:
  - On each valid bit: window <= {window[SYNC_LEN-2:0], din}.
  - Match compares the updated window with SYNC, so overlapping patterns are detected.
  - On match: next state COLLECT, bit_cnt=0, word_cnt=0, window cleared to 0.
- COLLECT (locked=1):
  - On each valid bit: shreg <= {shreg[WIDTH-2:0], din}; bit_cnt increments.
  - On the WIDTH-th bit the word is complete; bit_cnt wraps to 0 and word_cnt increments.
  - When word_cnt reaches WORDS_PER_FRAME: return to HUNT on that same edge, with window = 0.
  - Sync patterns inside COLLECT are ignored.
- Output register:
  - A completed word is accepted if dout_valid=0, or if dout_valid && dout_ready on the same edge (pass-through refill).
  - On accept: dout <= word, dout_valid=1. dout_valid rises on the edge that samples the last bit, so it is visible one cycle after that bit is presented.
  - Otherwise the word is dropped, dout is unchanged, and overflow <= 1.
  - dout_valid && dout_ready with no new word: dout_valid <= 0. dout holds its last value.
- Overflow:
  - Sticky; cleared by clear_ovf=1.
  - A set and a clear on the same edge: set wins.
- Width rules:
  - bit_cnt is $clog2(WIDTH) bits; word_cnt is $clog2(WORDS_PER_FRAME+1) bits.
  - No arithmetic overflow is possible beyond the wraps defined above.

Decomposition:
- Shared package:
  - state enum {HUNT, COLLECT}
  - default SYNC/SYNC_LEN constants
  - clog2-derived counter width localparams
- One natural sub-module: sync_pattern_detector, containing the shift window and comparator.
  - Inputs: clk, rst, din, din_valid, clear.
  - Output: match.
  - The parent drives clear on lock entry and on frame end.

Test Plan:
All scenarios use defaults: WIDTH=8, SYNC=1011, WORDS_PER_FRAME=2.
1. Reset: assert rst between edges -> all outputs 0 immediately, before any clk edge. Hold 3 cycles, release -> outputs stay 0 with din_valid=0.
2. Basic frame, dout_ready=1: bits 1,0,1,1, then 0xA5 MSB-first, then 0x3C.
   - locked=1 after the 4th bit.
   - dout=0xA5 with dout_valid=1 for 1 cycle after bit 12; dout=0x3C after bit 20.
   - locked=0 after bit 20; overflow=0.
3. Overlapping sync: bits 1,0,1,0,1,1, then 0xFF -> lock after the 6th bit (not the 4th); dout=0xFF.
4. Backpressure: dout_ready=0 through a full frame 0x12, 0x34.
   - dout=0x12 is held with dout_valid=1; 0x34 is dropped; overflow=1.
   - Then dout_ready=1 for one cycle -> dout_valid=0.
   - Pulse clear_ovf -> overflow=0.
5. Stalls: repeat scenario 2 with din_valid=0 for 2 cycles between every bit -> identical word values; each dout_valid rises 1 cycle after the last valid bit.
6. Reset mid-word: sync plus 5 bits of a word, then rst pulse.
   - Immediately locked=0 and dout_valid=0.
   - Bits 1,0,1,1 plus 0x5A then yield dout=0x5A, with no residue from the aborted word.
